// File: rtl/cpu_pkg.sv
// Shared types and default sizing for the issue-side operand path.
package cpu_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_SIZE  = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage : cpu_pkg

// File: rtl/operand_scoreboard.sv
// Busy bit per architectural register: set on issue of a writer, cleared on writeback.
module operand_scoreboard
  import cpu_pkg::*;
#(
  parameter  int unsigned SIZE       = DEF_SIZE,
  localparam int unsigned ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  output logic [SIZE-1:0]       busy,
  output logic                  err_c
);

  logic [SIZE-1:0] busy_q;
  logic [SIZE-1:0] busy_d;

  // A writeback to an idle register is flagged and leaves the vector untouched.
  assign err_c = clr && !busy_q[clr_idx];

  // Clear first so that a same-cycle set of the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (clr && busy_q[clr_idx]) begin
      busy_d[clr_idx] = 1'b0;
    end
    if (set) begin
      busy_d[set_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule : operand_scoreboard

// File: rtl/operand_fetch.sv
// Issue-side operand fetch: regfile read, writeback bypass, RAW/WAW stall and a one-entry output slot.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter  int unsigned WIDTH      = DEF_WIDTH,
  parameter  int unsigned SIZE       = DEF_SIZE,
  localparam int unsigned ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_rs1,
  input  logic [ADDR_WIDTH-1:0] req_rs2,
  input  logic [ADDR_WIDTH-1:0] req_rd,
  input  logic                  req_wr_en,
  output logic [ADDR_WIDTH-1:0] readnum1,
  output logic [ADDR_WIDTH-1:0] readnum2,
  input  logic [WIDTH-1:0]      rf_data1,
  input  logic [WIDTH-1:0]      rf_data2,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_num,
  input  logic [WIDTH-1:0]      wb_data,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [WIDTH-1:0]      op_a,
  output logic [WIDTH-1:0]      op_b,
  output logic [ADDR_WIDTH-1:0] op_rd,
  output logic                  op_wr_en,
  output logic                  wb_err
);

  slot_state_t           state_q;
  slot_state_t           state_d;
  logic [SIZE-1:0]       busy;
  logic                  sb_err_c;
  logic                  clr_rs1;
  logic                  clr_rs2;
  logic                  clr_rd;
  logic                  hazard;
  logic                  slot_free;
  logic                  accept;
  logic [WIDTH-1:0]      byp_a;
  logic [WIDTH-1:0]      byp_b;
  logic [WIDTH-1:0]      op_a_q;
  logic [WIDTH-1:0]      op_b_q;
  logic [ADDR_WIDTH-1:0] op_rd_q;
  logic                  op_wr_en_q;
  logic                  wb_err_q;

  assign readnum1 = req_rs1;
  assign readnum2 = req_rs2;

  // A writeback landing this cycle resolves any dependency on that register.
  assign clr_rs1 = wb_valid && (wb_num == req_rs1);
  assign clr_rs2 = wb_valid && (wb_num == req_rs2);
  assign clr_rd  = wb_valid && (wb_num == req_rd);

  assign hazard = (busy[req_rs1] && !clr_rs1)
               || (busy[req_rs2] && !clr_rs2)
               || (req_wr_en && busy[req_rd] && !clr_rd);

  assign slot_free = (state_q == EMPTY) || op_ready;
  assign req_ready = slot_free && !hazard;
  assign accept    = req_valid && req_ready;

  assign byp_a = clr_rs1 ? wb_data : rf_data1;
  assign byp_b = clr_rs2 ? wb_data : rf_data2;

  operand_scoreboard #(
    .SIZE (SIZE)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set     (accept && req_wr_en),
    .set_idx (req_rd),
    .clr     (wb_valid),
    .clr_idx (wb_num),
    .busy    (busy),
    .err_c   (sb_err_c)
  );

  // Slot next-state: refill on accept, drain when consumed without a replacement.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (op_ready && !accept) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_rd_q    <= '0;
      op_wr_en_q <= 1'b0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wb_err_q <= wb_err_q || sb_err_c;
      if (accept) begin
        op_a_q     <= byp_a;
        op_b_q     <= byp_b;
        op_rd_q    <= req_rd;
        op_wr_en_q <= req_wr_en;
      end
    end
  end

  assign op_valid = (state_q == FULL);
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_rd    = op_rd_q;
  assign op_wr_en = op_wr_en_q;
  assign wb_err   = wb_err_q;

endmodule : operand_fetch
